// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared encodings for the data-RAM port arbiter
package ram_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int unsigned RD_LAT_DEFAULT = 1;

    // Wide enough for RD_LAT-1 with RD_LAT up to 4.
    localparam int unsigned CNT_W = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       win,
    output logic       valid
);

    always_comb begin
        valid = |req;
        win   = REQ_A;
        case (req)
            2'b01:   win = REQ_A;
            2'b10:   win = REQ_B;
            // On a tie the port that did not win last time goes first.
            2'b11:   win = ~last;
            default: win = REQ_A;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one data-RAM port between two requesters
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = RD_LAT_DEFAULT
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iA_REQ,
    input  logic              iA_WR,
    input  logic [ADDR_W-1:0] iA_ADDR,
    input  logic [DATA_W-1:0] iA_WDATA,
    output logic              oA_GNT,
    output logic              oA_RVALID,
    output logic [DATA_W-1:0] oA_RDATA,
    input  logic              iB_REQ,
    input  logic              iB_WR,
    input  logic [ADDR_W-1:0] iB_ADDR,
    input  logic [DATA_W-1:0] iB_WDATA,
    output logic              oB_GNT,
    output logic              oB_RVALID,
    output logic [DATA_W-1:0] oB_RDATA,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic [DATA_W-1:0] oRAM_DATA,
    input  logic [DATA_W-1:0] iRAM_Q
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              a_gnt_q, a_gnt_d;
    logic              b_gnt_q, b_gnt_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              ram_ce_q, ram_ce_d;
    logic              ram_rd_q, ram_rd_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;

    logic              arb_win;
    logic              arb_valid;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req   ({iB_REQ, iA_REQ}),
        .last  (last_q),
        .win   (arb_win),
        .valid (arb_valid)
    );

    assign sel_wr    = (arb_win == REQ_B) ? iB_WR    : iA_WR;
    assign sel_addr  = (arb_win == REQ_B) ? iB_ADDR  : iA_ADDR;
    assign sel_wdata = (arb_win == REQ_B) ? iB_WDATA : iA_WDATA;

    // The command registers are loaded at the arbitration edge so that the
    // ISSUE cycle drives the RAM straight from flops.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        ram_ce_d   = 1'b0;
        ram_rd_d   = 1'b0;
        ram_wr_d   = 1'b0;
        ram_addr_d = '0;
        ram_data_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d    = ST_ISSUE;
                    last_d     = arb_win;
                    id_d       = arb_win;
                    wr_d       = sel_wr;
                    ram_ce_d   = 1'b1;
                    ram_wr_d   = sel_wr;
                    ram_rd_d   = ~sel_wr;
                    ram_addr_d = sel_addr;
                    ram_data_d = sel_wr ? sel_wdata : '0;
                    a_gnt_d    = (arb_win == REQ_A);
                    b_gnt_d    = (arb_win == REQ_B);
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (id_q == REQ_A) begin
                        a_rdata_d  = iRAM_Q;
                        a_rvalid_d = 1'b1;
                    end else begin
                        b_rdata_d  = iRAM_Q;
                        b_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            last_q     <= REQ_B;
            id_q       <= REQ_A;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            ram_ce_q   <= 1'b0;
            ram_rd_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            id_q       <= id_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            ram_ce_q   <= ram_ce_d;
            ram_rd_q   <= ram_rd_d;
            ram_wr_q   <= ram_wr_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign oA_GNT    = a_gnt_q;
    assign oB_GNT    = b_gnt_q;
    assign oA_RVALID = a_rvalid_q;
    assign oB_RVALID = b_rvalid_q;
    assign oA_RDATA  = a_rdata_q;
    assign oB_RDATA  = b_rdata_q;
    assign oRAM_CE   = ram_ce_q;
    assign oRAM_RD   = ram_rd_q;
    assign oRAM_WR   = ram_wr_q;
    assign oRAM_ADDR = ram_addr_q;
    assign oRAM_DATA = ram_data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed bench for ram_port_arbiter at RD_LAT 1 and 3
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_wr, b_req, b_wr;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata, ram_q;

    logic        a_gnt_1, a_rvalid_1, b_gnt_1, b_rvalid_1;
    logic        ram_ce_1, ram_rd_1, ram_wr_1;
    logic [31:0] a_rdata_1, b_rdata_1, ram_data_1;
    logic [7:0]  ram_addr_1;

    logic        a_gnt_3, a_rvalid_3, b_gnt_3, b_rvalid_3;
    logic        ram_ce_3, ram_rd_3, ram_wr_3;
    logic [31:0] a_rdata_3, b_rdata_3, ram_data_3;
    logic [7:0]  ram_addr_3;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_dut1 (
        .iCLK(clk), .iRST_N(rst_n),
        .iA_REQ(a_req), .iA_WR(a_wr), .iA_ADDR(a_addr), .iA_WDATA(a_wdata),
        .oA_GNT(a_gnt_1), .oA_RVALID(a_rvalid_1), .oA_RDATA(a_rdata_1),
        .iB_REQ(b_req), .iB_WR(b_wr), .iB_ADDR(b_addr), .iB_WDATA(b_wdata),
        .oB_GNT(b_gnt_1), .oB_RVALID(b_rvalid_1), .oB_RDATA(b_rdata_1),
        .oRAM_CE(ram_ce_1), .oRAM_RD(ram_rd_1), .oRAM_WR(ram_wr_1),
        .oRAM_ADDR(ram_addr_1), .oRAM_DATA(ram_data_1), .iRAM_Q(ram_q)
    );

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .iCLK(clk), .iRST_N(rst_n),
        .iA_REQ(a_req), .iA_WR(a_wr), .iA_ADDR(a_addr), .iA_WDATA(a_wdata),
        .oA_GNT(a_gnt_3), .oA_RVALID(a_rvalid_3), .oA_RDATA(a_rdata_3),
        .iB_REQ(b_req), .iB_WR(b_wr), .iB_ADDR(b_addr), .iB_WDATA(b_wdata),
        .oB_GNT(b_gnt_3), .oB_RVALID(b_rvalid_3), .oB_RDATA(b_rdata_3),
        .oRAM_CE(ram_ce_3), .oRAM_RD(ram_rd_3), .oRAM_WR(ram_wr_3),
        .oRAM_ADDR(ram_addr_3), .oRAM_DATA(ram_data_3), .iRAM_Q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [3:0] gnt_seq;
    int         n_gnt;

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        ram_q = '0;

        // Reset state
        tick(); tick();
        chk("rst_a_gnt", a_gnt_1, 0);
        chk("rst_b_gnt", b_gnt_1, 0);
        chk("rst_a_rvalid", a_rvalid_1, 0);
        chk("rst_b_rvalid", b_rvalid_1, 0);
        chk("rst_a_rdata", a_rdata_1, 0);
        chk("rst_b_rdata", b_rdata_1, 0);
        chk("rst_ce", ram_ce_1, 0);
        chk("rst_rd", ram_rd_1, 0);
        chk("rst_wr", ram_wr_1, 0);
        chk("rst_addr", ram_addr_1, 0);
        chk("rst_data", ram_data_1, 0);
        rst_n = 1'b1;

        // A write only
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h10; a_wdata = 32'hDEADBEEF;
        tick();
        chk("t1_a_gnt", a_gnt_1, 1);
        chk("t1_b_gnt", b_gnt_1, 0);
        chk("t1_ce", ram_ce_1, 1);
        chk("t1_wr", ram_wr_1, 1);
        chk("t1_rd", ram_rd_1, 0);
        chk("t1_addr", ram_addr_1, 32'h10);
        chk("t1_data", ram_data_1, 32'hDEADBEEF);
        a_req = 1'b0;
        tick();
        chk("t1_idle_gnt", a_gnt_1, 0);
        chk("t1_idle_ce", ram_ce_1, 0);
        chk("t1_idle_addr", ram_addr_1, 0);
        chk("t1_idle_data", ram_data_1, 0);

        // B read, RD_LAT=1
        b_req = 1'b1; b_wr = 1'b0; b_addr = 8'h20; b_wdata = 32'hFFFFFFFF;
        ram_q = 32'hBAD0BAD0;
        tick();
        chk("t2_b_gnt", b_gnt_1, 1);
        chk("t2_a_gnt", a_gnt_1, 0);
        chk("t2_rd", ram_rd_1, 1);
        chk("t2_wr", ram_wr_1, 0);
        chk("t2_addr", ram_addr_1, 32'h20);
        chk("t2_data", ram_data_1, 0);
        b_req = 1'b0;
        tick();
        chk("t2_wait_ce", ram_ce_1, 0);
        chk("t2_wait_rvalid", b_rvalid_1, 0);
        ram_q = 32'h12345678;
        tick();
        chk("t2_b_rvalid", b_rvalid_1, 1);
        chk("t2_b_rdata", b_rdata_1, 32'h12345678);
        chk("t2_a_rvalid", a_rvalid_1, 0);
        chk("t2_a_rdata", a_rdata_1, 0);
        ram_q = 32'h0;
        tick();
        chk("t2_b_rvalid_end", b_rvalid_1, 0);
        chk("t2_b_rdata_hold", b_rdata_1, 32'h12345678);

        // Both request continuously from reset: A writes, B reads
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h01; a_wdata = 32'h11;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 8'h02;
        gnt_seq = 4'hF;
        n_gnt = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("t3_rd_wr_excl", {31'b0, ram_rd_1 & ram_wr_1}, 0);
            chk("t3_gnt_excl", {31'b0, a_gnt_1 & b_gnt_1}, 0);
            if (a_gnt_1 || b_gnt_1) begin
                if (n_gnt < 4) gnt_seq[n_gnt] = b_gnt_1;
                n_gnt++;
            end
        end
        chk("t3_n_gnt", n_gnt, 4);
        chk("t3_gnt0_a", {31'b0, gnt_seq[0]}, 0);
        chk("t3_gnt1_b", {31'b0, gnt_seq[1]}, 1);
        chk("t3_gnt2_a", {31'b0, gnt_seq[2]}, 0);
        chk("t3_gnt3_b", {31'b0, gnt_seq[3]}, 1);
        a_req = 1'b0; b_req = 1'b0;

        // RD_LAT=3: A read, B request rises during WAIT
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h33;
        ram_q = 32'hBAD0BAD0;
        tick();
        chk("t4_a_gnt", a_gnt_3, 1);
        chk("t4_rd", ram_rd_3, 1);
        chk("t4_addr", ram_addr_3, 32'h33);
        chk("t4_data", ram_data_3, 0);
        a_req = 1'b0;
        tick();
        chk("t4_w0_ce", ram_ce_3, 0);
        b_req = 1'b1; b_wr = 1'b1; b_addr = 8'h44; b_wdata = 32'h55555555;
        tick();
        chk("t4_w1_ce", ram_ce_3, 0);
        chk("t4_w1_b_gnt", b_gnt_3, 0);
        tick();
        chk("t4_w2_ce", ram_ce_3, 0);
        chk("t4_w2_b_gnt", b_gnt_3, 0);
        chk("t4_w2_a_rvalid", a_rvalid_3, 0);
        ram_q = 32'hCAFEF00D;
        tick();
        chk("t4_a_rvalid", a_rvalid_3, 1);
        chk("t4_a_rdata", a_rdata_3, 32'hCAFEF00D);
        chk("t4_rv_b_gnt", b_gnt_3, 0);
        chk("t4_b_rdata", b_rdata_3, 0);
        chk("t4_rv_ce", ram_ce_3, 0);
        tick();
        chk("t4_b_gnt", b_gnt_3, 1);
        chk("t4_b_wr", ram_wr_3, 1);
        chk("t4_b_addr", ram_addr_3, 32'h44);
        chk("t4_b_data", ram_data_3, 32'h55555555);
        chk("t4_a_rvalid_end", a_rvalid_3, 0);
        b_req = 1'b0;
        tick();
        chk("t4_end_ce", ram_ce_3, 0);

        // Reset during WAIT of an A read (RD_LAT=3)
        a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h05;
        tick();
        chk("t5_a_gnt", a_gnt_3, 1);
        a_req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("t5_rst_a_gnt", a_gnt_3, 0);
        chk("t5_rst_a_rvalid", a_rvalid_3, 0);
        chk("t5_rst_a_rdata", a_rdata_3, 0);
        chk("t5_rst_b_gnt", b_gnt_3, 0);
        chk("t5_rst_ce", ram_ce_3, 0);
        chk("t5_rst_rd", ram_rd_3, 0);
        chk("t5_rst_addr", ram_addr_3, 0);
        rst_n = 1'b1;
        ram_q = 32'h11111111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_no_rvalid", a_rvalid_3, 0);
        end
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h06; a_wdata = 32'h66;
        b_req = 1'b1; b_wr = 1'b1; b_addr = 8'h07; b_wdata = 32'h77;
        tick();
        chk("t5_first_a_gnt3", a_gnt_3, 1);
        chk("t5_first_b_gnt3", b_gnt_3, 0);
        chk("t5_first_addr3", ram_addr_3, 32'h06);
        chk("t5_first_a_gnt1", a_gnt_1, 1);
        a_req = 1'b0;
        tick();
        tick();
        chk("t5_second_b_gnt3", b_gnt_3, 1);
        chk("t5_second_addr3", ram_addr_3, 32'h07);
        b_req = 1'b0;
        tick();

        // Back-to-back A writes, addresses 0,1,2
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h00; a_wdata = 32'hA0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_gnt", a_gnt_1, 1);
            chk("t6_addr", ram_addr_1, i);
            chk("t6_data", ram_data_1, 32'hA0 + i);
            a_addr = 8'(i + 1);
            a_wdata = 32'hA0 + 32'(i + 1);
            if (i == 2) a_req = 1'b0;
            tick();
            chk("t6_gap_gnt", a_gnt_1, 0);
            chk("t6_gap_ce", ram_ce_1, 0);
        end
        tick();
        chk("t6_tail_gnt", a_gnt_1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single data-RAM port (CE/RD/WR, word address, write data, read data) between two requesters.
  - Port A: core load/store path (RV32I/RV32C load/store units such as c.swsp/c.lwsp).
  - Port B: secondary master (debug loader / DMA).
- Round-robin arbitration; one access in flight at a time.
- Sequences the RAM command cycle and the read-latency wait.
- Returns read data only to the port that issued the read.

Parameters:
- ADDR_W, 8, RAM word-address width (byte address >> 2, computed by the requester).
- DATA_W, 32, data width.
- RD_LAT, 1, RAM read latency in cycles from command cycle to valid iRAM_Q; legal range 1..4.

Ports:
- iCLK  in  1  clock; all logic on rising edge.
- iRST_N  in  1  synchronous reset, active-low.
- iA_REQ  in  1  port A request; held high until oA_GNT seen, dropped the cycle after.
- iA_WR  in  1  port A: 1 = write, 0 = read; stable while iA_REQ high.
- iA_ADDR  in  ADDR_W  port A word address.
- iA_WDATA  in  DATA_W  port A write data.
- oA_GNT  out  1  one-cycle pulse, coincident with the RAM command cycle for port A.
- oA_RVALID  out  1  one-cycle pulse, read data valid for port A.
- oA_RDATA  out  DATA_W  port A read data; holds until the next port A read completes.
- iB_REQ, iB_WR, iB_ADDR, iB_WDATA, oB_GNT, oB_RVALID, oB_RDATA: same as port A, for port B.
- oRAM_CE  out  1  RAM chip enable.
- oRAM_RD  out  1  RAM read strobe.
- oRAM_WR  out  1  RAM write strobe.
- oRAM_ADDR  out  ADDR_W  RAM word address.
- oRAM_DATA  out  DATA_W  RAM write data.
- iRAM_Q  in  DATA_W  RAM read data.

Behaviour:
- Reset (iRST_N low at a rising edge):
  - State goes to IDLE; last-grant pointer set to B, so A wins the first tie.
  - All outputs 0, including oX_RDATA.
  - A reset mid-WAIT discards the pending read; no RVALID is produced.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any iX_REQ is high, select a winner and go to ISSUE; otherwise stay in IDLE.
  - Winner capture: ID, WR, ADDR and WDATA are latched at this edge.
  - Selection: if only one port requests, it wins. If both request, the port not granted last wins; the pointer updates to the winner.
- ISSUE (exactly 1 cycle):
  - oRAM_CE = 1; oRAM_ADDR = latched address; oX_GNT = 1 for the winner only.
  - Write: oRAM_WR = 1, oRAM_RD = 0, oRAM_DATA = latched data; next state IDLE.
  - Read: oRAM_RD = 1, oRAM_WR = 0, oRAM_DATA = 0; load the latency counter with RD_LAT-1; next state WAIT.
- WAIT:
  - oRAM_CE/RD/WR all 0.
  - Counter decrements each cycle.
  - On the cycle the counter reads 0 (ISSUE + RD_LAT), sample iRAM_Q into the winner's oX_RDATA, pulse the winner's oX_RVALID on the following cycle, and go to IDLE.
  - The other port's RDATA is unchanged.
- Timing:
  - Read: request seen at edge T0; GNT and command at T0+1; RVALID at T0+2+RD_LAT.
  - Write: one access every 2 cycles at most.
- RVALID and a new arbitration may occur in the same IDLE cycle.
- Requests arriving in ISSUE or WAIT are not acknowledged and must stay high; they are arbitrated at the next IDLE.
- When CE = 0: RD, WR, ADDR and DATA are all 0.
- oRAM_RD and oRAM_WR are never both 1.
- Starvation bound: a continuously requesting port is granted within 2 grants.
- A requester violating the hold rule (REQ dropped before GNT) may lose its slot; a request already latched still issues.

Decomposition:
- Shared package ram_arb_pkg:
  - State encodings IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2.
  - Requester IDs REQ_A = 1'b0, REQ_B = 1'b1.
  - Default RD_LAT.
- One sub-module rr_arb2: combinational 2-way round-robin pick.
  - Inputs: req[1:0], last.
  - Outputs: win, valid.
  - The pointer register lives in the parent.

Test Plan:
- A write only: iA_REQ=1, WR=1, ADDR=8'h10, WDATA=32'hDEADBEEF → next cycle oA_GNT=1, oRAM_CE=1, oRAM_WR=1, ADDR=8'h10, DATA=32'hDEADBEEF; oB_GNT never 1.
- B read, RD_LAT=1: iRAM_Q=32'h12345678 in the cycle after ISSUE → oB_RVALID pulses 3 cycles after the request edge with oB_RDATA=32'h12345678; oA_RDATA stays 0.
- Both ports request continuously (A writes, B reads) from reset → grant order A,B,A,B; no port waits more than one other grant; RD and WR are never both high.
- RD_LAT=3, A read while iB_REQ rises during WAIT → B's GNT occurs only in the cycle after oA_RVALID's IDLE decision; oRAM_CE=0 throughout WAIT.
- iRST_N=0 during WAIT of an A read → no oA_RVALID; all outputs 0 the next cycle; the first grant after reset goes to A when both request.
- Back-to-back writes from A only (REQ re-raised in IDLE) → GNT every 2nd cycle, addresses 0,1,2 issued in order.
